// File: rtl/boreal_sram_arbiter.sv
// Two-master round-robin arbiter sharing one boreal_sram_tile port between CPU (m0) and DMA (m1).
// Define BOREAL_ARB_TIMEOUT_EN to force an error response after TIMEOUT_CYCLES stalled WAIT cycles.
module boreal_sram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  m_req_valid,
  output logic [1:0]  m_req_ready,
  input  logic [1:0]  m_req_we,
  input  logic [63:0] m_req_addr,
  input  logic [63:0] m_req_wdata,
  input  logic [7:0]  m_req_wstrb,
  output logic [1:0]  m_resp_valid,
  output logic [31:0] m_resp_rdata,
  output logic        m_resp_err,
  output logic        s_req_valid,
  output logic        s_req_we,
  output logic [31:0] s_req_addr,
  output logic [31:0] s_req_wdata,
  output logic [3:0]  s_req_wstrb,
  input  logic        s_resp_valid,
  input  logic [31:0] s_resp_rdata,
  input  logic        s_resp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("boreal_sram_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        winner;
  logic        accept;

`ifdef BOREAL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Expiry fires on the edge that ends the TIMEOUT_CYCLES-th WAIT cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // A lone requester always wins; prio only breaks ties.
  always_comb begin
    case (m_req_valid)
      2'b10:   winner = 1'b1;
      2'b11:   winner = prio_q;
      default: winner = 1'b0;
    endcase
  end

  assign accept      = (state_q == S_IDLE) && (m_req_valid != 2'b00);
  assign m_req_ready = accept ? {winner, ~winner} : 2'b00;

  always_comb begin
    // NOTE: every target gets a default first so no path leaves a latch behind.
    state_d      = state_q;
    prio_d       = prio_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    resp_valid_d = 2'b00;
    rdata_d      = rdata_q;
    err_d        = err_q;
`ifdef BOREAL_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = m_req_we[winner];
          addr_d  = winner ? m_req_addr[63:32]  : m_req_addr[31:0];
          wdata_d = winner ? m_req_wdata[63:32] : m_req_wdata[31:0];
          wstrb_d = winner ? m_req_wstrb[7:4]   : m_req_wstrb[3:0];
          owner_d = winner;
          prio_d  = ~winner;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
`ifdef BOREAL_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (s_resp_valid) begin
          resp_valid_d = {owner_q, ~owner_q};
          rdata_d      = s_resp_rdata;
          err_d        = s_resp_err;
          state_d      = S_IDLE;
        end
`ifdef BOREAL_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          resp_valid_d = {owner_q, ~owner_q};
          rdata_d      = '0;
          err_d        = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      resp_valid_q <= 2'b00;
      rdata_q      <= '0;
      err_q        <= 1'b0;
`ifdef BOREAL_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
`ifdef BOREAL_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign s_req_valid  = (state_q == S_REQ);
  assign s_req_we     = we_q;
  assign s_req_addr   = addr_q;
  assign s_req_wdata  = wdata_q;
  assign s_req_wstrb  = wstrb_q;
  assign m_resp_valid = resp_valid_q;
  assign m_resp_rdata = rdata_q;
  assign m_resp_err   = err_q;

endmodule

// File: tb/tb_boreal_sram_arbiter.sv
// Self-checking bench for boreal_sram_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a behavioural SRAM slave.
module tb_boreal_sram_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_req_valid, m_req_ready, m_req_we, m_resp_valid;
  logic [63:0] m_req_addr, m_req_wdata;
  logic [7:0]  m_req_wstrb;
  logic [31:0] m_resp_rdata;
  logic        m_resp_err;
  logic        s_req_valid, s_req_we;
  logic [31:0] s_req_addr, s_req_wdata;
  logic [3:0]  s_req_wstrb;
  logic        s_resp_valid;
  logic [31:0] s_resp_rdata;
  logic        s_resp_err;

  always #5 clk = ~clk;

  boreal_sram_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata), .m_resp_err(m_resp_err),
    .s_req_valid(s_req_valid), .s_req_we(s_req_we), .s_req_addr(s_req_addr),
    .s_req_wdata(s_req_wdata), .s_req_wstrb(s_req_wstrb),
    .s_resp_valid(s_resp_valid), .s_resp_rdata(s_resp_rdata), .s_resp_err(s_resp_err)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stimulus controls
  req_t mq0[$], mq1[$];
  bit   nxt_rst_n = 1'b0;
  bit   chk_en    = 1'b0;
  bit   drop_en   = 1'b0;
  bit   spur_en   = 1'b0;
  bit   force_spur = 1'b0;
  bit   err_en    = 1'b0;
  bit   mute      = 1'b0;
  bit   check_lat = 1'b0;
  int   lat_exp   = 3;
  int   dly_min   = 0;
  int   dly_max   = 0;

  // Reference model: one transaction in flight at most
  bit          md_busy, md_req, md_prio, md_owner, md_rv, md_err;
  req_t        md_lat;
  logic [31:0] md_rdata;
  int          md_wait;
  int          acc_q[$];
  int          grant_log[$], grant_cyc[$];

  // Behavioural SRAM slave
  logic [31:0] mem [256];
  bit          sl_pend = 1'b0;
  int          sl_wait = 0;
  req_t        sl_req;

  function automatic req_t rnd_req();
    req_t r;
    r.we    = 1'($urandom);
    r.addr  = {22'b0, 8'($urandom), 2'b00};
    r.wdata = $urandom;
    r.wstrb = 4'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    md_busy = 0; md_req = 0; md_prio = 0; md_owner = 0;
    md_rv = 0; md_err = 0; md_rdata = '0; md_lat = '0; md_wait = 0;
    acc_q.delete();
  endtask

  task automatic run_cycle();
    logic [1:0]  vld, exp_rdy;
    bit          w, any, drv_rv;
    logic [31:0] drv_rd;
    logic        drv_err;
    req_t        r0, r1;
    int          a;
    @(negedge clk);
    cyc++;
    if (chk_en) begin
      check("s_req_valid", 96'(s_req_valid), 96'(md_req));
      if (md_req) check("s_req_fields", {s_req_we, s_req_addr, s_req_wdata, s_req_wstrb}, md_lat);
      check("m_resp_valid", 96'(m_resp_valid), md_rv ? (md_owner ? 96'd2 : 96'd1) : 96'd0);
      check("m_resp_data", {m_resp_err, m_resp_rdata}, {md_err, md_rdata});
      if (m_resp_valid != 2'b00 && acc_q.size() > 0) begin
        a = acc_q.pop_front();
        if (check_lat) check("latency", 96'(cyc - a), 96'(lat_exp));
      end
    end
    // Slave response for this cycle
    drv_rv = 0; drv_rd = $urandom; drv_err = 1'b0;
    if (sl_pend && !mute) begin
      if (sl_wait == 0) begin
        drv_rv  = 1;
        drv_rd  = sl_req.we ? 32'h0 : mem[sl_req.addr[9:2]];
        drv_err = err_en && ($urandom_range(7) == 0);
        sl_pend = 0;
      end else begin
        sl_wait--;
      end
    end else if (!sl_pend && (force_spur || (spur_en && $urandom_range(5) == 0))) begin
      drv_rv  = 1;
      drv_err = 1'($urandom);
    end
    // Master requests
    r0  = (mq0.size() != 0) ? mq0[0] : rnd_req();
    r1  = (mq1.size() != 0) ? mq1[0] : rnd_req();
    vld = {mq1.size() != 0, mq0.size() != 0};
    if (drop_en) vld &= 2'($urandom);
    if (!nxt_rst_n) vld = 2'b00;
    m_req_valid  = vld;
    m_req_we     = {r1.we, r0.we};
    m_req_addr   = {r1.addr, r0.addr};
    m_req_wdata  = {r1.wdata, r0.wdata};
    m_req_wstrb  = {r1.wstrb, r0.wstrb};
    rst_n        = nxt_rst_n;
    s_resp_valid = drv_rv;
    s_resp_rdata = drv_rd;
    s_resp_err   = drv_err;
    #1;
    any     = (vld != 2'b00) && !md_busy;
    w       = (vld == 2'b10) ? 1'b1 : ((vld == 2'b11) ? md_prio : 1'b0);
    exp_rdy = any ? (w ? 2'b10 : 2'b01) : 2'b00;
    if (chk_en) check("m_req_ready", 96'(m_req_ready), 96'(exp_rdy));
    if (m_req_ready == 2'b01 || m_req_ready == 2'b10) begin
      grant_log.push_back(int'(m_req_ready[1]));
      grant_cyc.push_back(cyc);
    end
    // Model advances across the coming edge
    if (!nxt_rst_n) begin
      model_reset();
    end else begin
      md_rv = 0;
      if (md_busy && !md_req) begin
        md_wait++;
        if (drv_rv) begin
          md_rv = 1; md_rdata = drv_rd; md_err = drv_err; md_busy = 0;
        end
`ifdef BOREAL_ARB_TIMEOUT_EN
        else if (md_wait == TMO) begin
          md_rv = 1; md_rdata = '0; md_err = 1; md_busy = 0;
        end
`endif
      end
      if (md_req) begin
        md_req  = 0;
        md_wait = 0;
      end
      if (any) begin
        md_lat   = w ? r1 : r0;
        md_owner = w;
        md_prio  = ~w;
        md_busy  = 1;
        md_req   = 1;
        acc_q.push_back(cyc);
        if (w) void'(mq1.pop_front());
        else   void'(mq0.pop_front());
      end
    end
    // Slave captures the request it sees this cycle
    if (s_req_valid === 1'b1) begin
      sl_req  = {s_req_we, s_req_addr, s_req_wdata, s_req_wstrb};
      sl_pend = 1;
      sl_wait = $urandom_range(dly_max, dly_min);
      if (s_req_we) begin
        for (int b = 0; b < 4; b++)
          if (s_req_wstrb[b]) mem[s_req_addr[9:2]][8*b +: 8] = s_req_wdata[8*b +: 8];
      end
    end
  endtask

  task automatic do_reset();
    nxt_rst_n = 0;
    repeat (2) run_cycle();
    nxt_rst_n = 1;
  endtask

  initial begin
    req_t r;
    int   n;
    rst_n = 1'b0;
    m_req_valid = '0; m_req_we = '0; m_req_addr = '0; m_req_wdata = '0; m_req_wstrb = '0;
    s_resp_valid = 1'b0; s_resp_rdata = '0; s_resp_err = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    model_reset();

    // Reset: first edge brings the DUT out of X, then outputs are checked against zeros
    nxt_rst_n = 0;
    run_cycle();
    chk_en = 1;
    do_reset();

    // m0 write 0x10 then m0 read 0x10
    check_lat = 1;
    lat_exp   = 3;
    r = '{we: 1'b1, addr: 32'h10, wdata: 32'hDEADBEEF, wstrb: 4'hF};
    mq0.push_back(r);
    r = '{we: 1'b0, addr: 32'h10, wdata: 32'h0, wstrb: 4'h0};
    mq0.push_back(r);
    repeat (10) run_cycle();
    check("t1_rdata", 96'(m_resp_rdata), 96'h0DEADBEEF);
    check("t1_err", 96'(m_resp_err), 96'd0);
    check("t1_grants", 96'(grant_log.size()), 96'd2);

    // Both masters continuously valid after reset: strict alternation from m0
    do_reset();
    grant_log.delete(); grant_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      mq0.push_back(rnd_req());
      mq1.push_back(rnd_req());
    end
    repeat (26) run_cycle();
    check("t2_ngrants", 96'(grant_log.size()), 96'd8);
    for (int i = 0; i < 8; i++)
      check("t2_order", 96'((i < grant_log.size()) ? grant_log[i] : 99), 96'(i % 2));

    // m1 alone four times back-to-back, then a tie must go to m0
    grant_log.delete(); grant_cyc.delete();
    for (int i = 0; i < 4; i++) mq1.push_back(rnd_req());
    repeat (14) run_cycle();
    check("t3_ngrants", 96'(grant_log.size()), 96'd4);
    for (int i = 1; i < 4; i++)
      if (i < grant_cyc.size())
        check("t3_spacing", 96'(grant_cyc[i] - grant_cyc[i-1]), 96'd3);
    mq0.push_back(rnd_req());
    mq1.push_back(rnd_req());
    repeat (8) run_cycle();
    check("t3_tie_m0", 96'((grant_log.size() > 4) ? grant_log[4] : 99), 96'd0);

    // Spurious slave response while idle is ignored; arbiter stays ready
    force_spur = 1;
    run_cycle();
    force_spur = 0;
    repeat (3) run_cycle();
    n = grant_log.size();
    mq1.push_back(rnd_req());
    run_cycle();
    check("t4_grant_now", 96'(grant_log.size() - n), 96'd1);
    repeat (4) run_cycle();

    // Reset during WAIT; the late slave response must not surface
    dly_min = 4; dly_max = 4;
    mq0.push_back(rnd_req());
    repeat (3) run_cycle();
    nxt_rst_n = 0;
    run_cycle();
    nxt_rst_n = 1;
    repeat (4) run_cycle();
    dly_min = 0; dly_max = 0;
    grant_log.delete(); grant_cyc.delete();
    mq0.push_back(rnd_req());
    mq1.push_back(rnd_req());
    repeat (8) run_cycle();
    check("t5_first_m0", 96'((grant_log.size() > 0) ? grant_log[0] : 99), 96'd0);

    // Randomized traffic: drops, spurious responses, slave delays and errors, occasional reset
    check_lat = 0;
    drop_en = 1; spur_en = 1; err_en = 1; dly_max = 3;
    for (int i = 0; i < 3000; i++) begin
      if (mq0.size() < 2 && $urandom_range(3) == 0) mq0.push_back(rnd_req());
      if (mq1.size() < 2 && $urandom_range(3) == 0) mq1.push_back(rnd_req());
      nxt_rst_n = ($urandom_range(299) != 0);
      run_cycle();
    end
    nxt_rst_n = 1;
    drop_en = 0; spur_en = 0; err_en = 0; dly_max = 0;
    mq0.delete(); mq1.delete();
    sl_pend = 0;
    do_reset();

`ifdef BOREAL_ARB_TIMEOUT_EN
    // Silent slave: error response after TMO WAIT cycles, then normal service resumes
    check_lat = 1;
    lat_exp   = TMO + 2;
    mute = 1;
    mq0.push_back(rnd_req());
    repeat (TMO + 6) run_cycle();
    check("tmo_err", 96'(m_resp_err), 96'd1);
    check("tmo_rdata", 96'(m_resp_rdata), 96'd0);
    mute = 0;
    sl_pend = 0;
    lat_exp = 3;
    mq1.push_back(rnd_req());
    repeat (6) run_cycle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
